// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, fetch FSM states and default widths.
// Used by instruction_fetch and branch_resolve.
package cpu_pkg;

    localparam int unsigned PC_W_DEF    = 8;
    localparam int unsigned INSTR_W_DEF = 16;
    localparam int unsigned OPC_W       = 5;

    localparam logic [OPC_W-1:0] OP_NOP   = 5'h00;
    localparam logic [OPC_W-1:0] OP_ADD   = 5'h01;
    localparam logic [OPC_W-1:0] OP_SUB   = 5'h02;
    localparam logic [OPC_W-1:0] OP_AND   = 5'h03;
    localparam logic [OPC_W-1:0] OP_OR    = 5'h04;
    localparam logic [OPC_W-1:0] OP_XOR   = 5'h05;
    localparam logic [OPC_W-1:0] OP_NOT   = 5'h06;
    localparam logic [OPC_W-1:0] OP_SHL   = 5'h07;
    localparam logic [OPC_W-1:0] OP_SHR   = 5'h08;
    localparam logic [OPC_W-1:0] OP_LOAD  = 5'h09;
    localparam logic [OPC_W-1:0] OP_STORE = 5'h0A;
    localparam logic [OPC_W-1:0] OP_MOV   = 5'h0B;
    localparam logic [OPC_W-1:0] OP_CMP   = 5'h0C;
    localparam logic [OPC_W-1:0] OP_JMP   = 5'h0D;
    localparam logic [OPC_W-1:0] OP_JZ    = 5'h0E;
    localparam logic [OPC_W-1:0] OP_JNZ   = 5'h0F;
    localparam logic [OPC_W-1:0] OP_JL    = 5'h10;
    localparam logic [OPC_W-1:0] OP_JG    = 5'h11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    // Opcodes above the last defined one (5'h12..5'h1F) are unassigned.
    function automatic logic is_illegal_op(input logic [OPC_W-1:0] op);
        return op > OP_JG;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch condition evaluation from control-unit branch strobes and the
// registered Z/N flags. Several strobes asserted together simply OR.
// Ports:
//   is_jump, is_jz, is_jnz, is_jl, is_jg : branch controls
//   z, n                                  : current flag register
//   taken_c                               : combinational branch-taken
module branch_resolve
    import cpu_pkg::*;
(
    input  logic is_jump,
    input  logic is_jz,
    input  logic is_jnz,
    input  logic is_jl,
    input  logic is_jg,
    input  logic z,
    input  logic n,
    output logic taken_c
);

    assign taken_c = is_jump
                   | (is_jz  &  z)
                   | (is_jnz & ~z)
                   | (is_jl  &  n)
                   | (is_jg  & ~z & ~n);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: FETCH -> WAIT -> ISSUE loop, owns pc, the
// instruction register and the {Z,N} flag register.
// Optional macro FETCH_HALT_ON_ILLEGAL_EN: unassigned opcodes stop fetch in a
// HALT state (port halted present); otherwise they retire as a nop.
// Ports:
//   clk, reset             : clock, async active-high reset
//   im_req, im_addr        : instruction-memory read request / address
//   im_data, im_valid      : read data and its qualifier (used only in WAIT)
//   instr, opcode          : instruction register and its opcode field
//   instr_valid            : instr/opcode valid (ISSUE)
//   stall                  : downstream cannot retire the issued instruction
//   is_jz..is_jump         : branch controls for the current opcode
//   flags_write, alu_*     : flag-update enable and ALU result flags
//   pc                     : program counter
//   halted                 : fetch stopped (macro builds only)
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    output logic               im_req,
    output logic [PC_W-1:0]    im_addr,
    input  logic [INSTR_W-1:0] im_data,
    input  logic               im_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [OPC_W-1:0]   opcode,
    output logic               instr_valid,
    input  logic               stall,
    input  logic               is_jz,
    input  logic               is_jnz,
    input  logic               is_jl,
    input  logic               is_jg,
    input  logic               is_jump,
    input  logic               flags_write,
    input  logic               alu_zero,
    input  logic               alu_neg,
    output logic [PC_W-1:0]    pc
`ifdef FETCH_HALT_ON_ILLEGAL_EN
    ,
    output logic               halted
`endif
);

    fetch_state_t    state;
    fetch_state_t    state_n;
    logic [PC_W-1:0] pc_n;
    logic            flags_load;
    logic            flag_z;
    logic            flag_n;
    logic            taken_c;
    logic [PC_W-1:0] target;

    assign opcode  = instr[INSTR_W-1 -: OPC_W];
    assign target  = instr[PC_W-1:0];
    // pc is a register, so the request address is registered too
    assign im_addr = pc;

    // Branch decision uses the flags as they stand before this cycle's update
    branch_resolve u_branch_resolve (
        .is_jump (is_jump),
        .is_jz   (is_jz),
        .is_jnz  (is_jnz),
        .is_jl   (is_jl),
        .is_jg   (is_jg),
        .z       (flag_z),
        .n       (flag_n),
        .taken_c (taken_c)
    );

    // Next-state, next-pc and flag-load decode
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        flags_load = 1'b0;
        case (state)
            S_FETCH: state_n = S_WAIT;
            S_WAIT: begin
                if (im_valid) begin
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    flags_load = flags_write;
`ifdef FETCH_HALT_ON_ILLEGAL_EN
                    if (is_illegal_op(opcode)) begin
                        state_n = S_HALT;
                    end else begin
                        state_n = S_FETCH;
                        pc_n    = taken_c ? target : pc + PC_W'(1);
                    end
`else
                    state_n = S_FETCH;
                    // Unassigned opcodes retire as a nop regardless of strobes
                    if (is_illegal_op(opcode)) begin
                        pc_n = pc + PC_W'(1);
                    end else begin
                        pc_n = taken_c ? target : pc + PC_W'(1);
                    end
`endif
                end
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= '0;
            instr       <= '0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            im_req      <= 1'b1;
            instr_valid <= 1'b0;
`ifdef FETCH_HALT_ON_ILLEGAL_EN
            halted      <= 1'b0;
`endif
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (state == S_WAIT && im_valid) begin
                instr <= im_data;
            end
            if (flags_load) begin
                flag_z <= alu_zero;
                flag_n <= alu_neg;
            end
            im_req      <= (state_n == S_FETCH);
            instr_valid <= (state_n == S_ISSUE);
`ifdef FETCH_HALT_ON_ILLEGAL_EN
            halted      <= (state_n == S_HALT);
`endif
        end
    end

endmodule
